// File: rtl/loader_pkg.sv
// Shared types for the UART word loader: FSM states, word width and byte-index sizing.
package loader_pkg;

  typedef enum logic [1:0] {
    LEN  = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  typedef logic [8*WORD_BYTES-1:0] word_t;

endpackage

// File: rtl/word_assembler.sv
// Collects bytes MSB-first into a big-endian word; word_done_o fires combinationally
// with the last byte so the caller can register the completed word on the same edge.
module word_assembler
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output word_t      word_o,
  output logic       word_done_o
);

  logic [8*(WORD_BYTES-1)-1:0] shift_q;
  logic [IDX_W-1:0]            idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[8*(WORD_BYTES-2)-1:0], byte_i};
      idx_q   <= idx_q + IDX_W'(1);
    end
  end

  // The 4th byte is not stored; it is merged directly into the outgoing word.
  assign word_o      = {shift_q, byte_i};
  assign word_done_o = byte_valid_i && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/uart_word_loader.sv
// Loads a length-prefixed stream of big-endian 32-bit words from a UART into memory,
// flagging completion and headers that announce more words than the memory holds.
module uart_word_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              restart,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              overflow
);

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  state_e            state_q, state_d;
  word_t             n_q;
  logic [31:0]       word_idx_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  word_t             wr_data_q;
  logic              overflow_q;

  logic  asm_valid;
  logic  asm_clear;
  logic  asm_done;
  word_t asm_word;
  logic  last_word;
  logic  in_range;

  // restart outranks a coincident byte, and DONE ignores the receiver entirely
  assign asm_valid = rx_valid && !restart && (state_q != DONE);
  assign asm_clear = restart || (state_d != state_q);
  assign last_word = (word_idx_q + 32'd1) == n_q;
  assign in_range  = (word_idx_q >> ADDR_W) == 32'd0;

  word_assembler u_asm (
    .clk          (CLK),
    .rst_n        (RST_N),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_done_o  (asm_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= LEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = LEN;
    end else begin
      case (state_q)
        LEN:     if (asm_done) state_d = (asm_word == '0) ? DONE : DATA;
        DATA:    if (asm_done && last_word) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = LEN;
      endcase
    end
  end

  always_comb begin
    done = (state_q == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n_q        <= '0;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (restart) begin
        word_idx_q <= '0;
        overflow_q <= 1'b0;
      end else if (asm_done && state_q == LEN) begin
        n_q        <= asm_word;
        word_idx_q <= '0;
        if ({1'b0, asm_word} > CAPACITY) overflow_q <= 1'b1;
      end else if (asm_done && state_q == DATA) begin
        // Out-of-range words still advance the count so DONE tracks N exactly.
        word_idx_q <= word_idx_q + 32'd1;
        if (in_range) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= word_idx_q[ADDR_W-1:0];
          wr_data_q <= asm_word;
        end
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign overflow = overflow_q;

endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 Parameter: ADDR_W, default 14, word-address width of the target memory (capacity 2^ADDR_W words).
REQ-002 Port: CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous and active-low.
REQ-004 Port: rx_data  input  8  byte from the UART receiver; valid only while rx_valid is high.
REQ-005 Port: rx_valid  input  1  single-cycle strobe, one per received byte.
REQ-006 Port: restart  input  1  synchronous pulse; abandons any transfer and re-arms for a new length header.
REQ-007 Port: wr_en  output  1  one-cycle memory write strobe.
REQ-008 Port: wr_addr  output  ADDR_W  word address of the current write.
REQ-009 Port: wr_data  output  32  assembled word.
REQ-010 Port: done  output  1  high once all announced words are received; held until restart or reset.
REQ-011 Port: overflow  output  1  sticky; set when the announced count exceeds 2^ADDR_W.

Function
REQ-012 Stream format: a 4-byte big-endian word count N, then N words, each 4 bytes big-endian (first byte goes to bits [31:24]).
REQ-013 States: LEN (collecting header), DATA (collecting words), DONE; exit from reset goes to LEN.
REQ-014 A 2-bit byte index counts rx_valid strobes in LEN and DATA, wraps 3->0 on the 4th byte, and clears on every state change.
REQ-015 LEN: the 4th byte latches N. If N==0, go to DONE; otherwise go to DATA with the word counter and wr_addr at 0.
REQ-016 DATA: the 4th byte of a word drives wr_en high exactly one cycle after that byte's rx_valid, with wr_data = the assembled word and wr_addr = the current word index.
REQ-017 Word index increments in the cycle after each wr_en; after the N-th word, go to DONE in the same cycle as the write.
REQ-018 Words with index >= 2^ADDR_W: no write; the word is still counted toward N. overflow is set in the cycle N is latched if N > 2^ADDR_W.
REQ-019 wr_addr and wr_data hold their last values when wr_en is low.
REQ-020 DONE: rx_valid is ignored; done=1.
REQ-021 restart: in the next cycle, go to LEN and clear the byte index, word index, done and overflow. If restart coincides with rx_valid, restart wins and the byte is discarded.
REQ-022 The word counter is 32 bits wide; N up to 2^32-1 is accepted without wrap.

Reset
REQ-023 RST_N low asynchronously forces: state LEN, byte index 0, word index 0, wr_en 0, wr_addr 0, wr_data 0, done 0, overflow 0.
REQ-024 Reset asserted mid-word or mid-header discards all partial bytes; no write is issued during reset or in the first cycle after it.
REQ-025 Reset release is taken synchronously to CLK by the enclosing design; the block needs no internal synchronizer.

Structure
REQ-026 Shared package loader_pkg holds: the state enum (LEN, DATA, DONE), WORD_BYTES=4, and the 32-bit word typedef.
REQ-027 One sub-module, word_assembler, holds the byte shift register, byte index and word-complete pulse. It is instantiated once and serves both the header and data phases.

Verification
REQ-028 Stream 00 00 00 02 | DE AD BE EF | 01 02 03 04 -> writes (addr 0, 0xDEADBEEF) then (addr 1, 0x01020304), each one cycle after its last byte; done=1 after the second write.
REQ-029 Header 00 00 00 00 -> no wr_en, done=1 one cycle after the 4th byte; further bytes produce no writes.
REQ-030 ADDR_W=2, header 00 00 00 05, then 5 words -> overflow=1 after the header, writes only to addr 0..3, done=1 after the 5th word.
REQ-031 Header N=3, two full words, then 2 bytes, then a restart pulse -> done=0, no third write. A new stream with N=1 and word 0xCAFEF00D writes addr 0.
REQ-032 RST_N low for 1 cycle after the 2nd byte of a data word -> all outputs 0. A fresh header of N=1 then word 0x11223344 -> a single write of 0x11223344 at addr 0.
REQ-033 restart and rx_valid in the same cycle -> the byte is dropped; the next 4 bytes are taken as the header.
